// File: rtl/cross_product_sequencer.sv
// ---------------------------------------------------------------------------
// cross_product_sequencer
//
// Purpose:
//   Computes n = u x v for FP21 vectors by issuing three (a*b)+(c*d) jobs to an
//   external multiply-add datapath of fixed latency LAT. Each job is tracked by
//   a LAT-deep tag pipeline, and the returning result is steered into
//   n_x / n_y / n_z. The finished vector is held until the sink takes it.
//
// FP21 word: {sign[20], exp[19:13] (7 bits), frac[12:0] (13 bits)}.
//
// Parameters:
//   LAT        datapath latency in clocks (1..16)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      accept handshake for operand vectors u, v
//   u_x..u_z, v_x..v_z       FP21 operand vectors
//   op_issue, op_a..op_d     datapath request, computes (a*b)+(c*d)
//   res                      datapath result, LAT cycles after op_issue
//   out_valid / out_ready    result handshake
//   n_x, n_y, n_z            FP21 cross-product result
//
// Optional feature (macro CROSS_SEQ_ZERO_FLUSH_EN):
//   When defined, any captured result with a zero exponent (zero or denormal)
//   is stored as +0. When undefined, results are stored bit-exact.
// ---------------------------------------------------------------------------
module cross_product_sequencer #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [20:0] u_x,
    input  logic [20:0] u_y,
    input  logic [20:0] u_z,
    input  logic [20:0] v_x,
    input  logic [20:0] v_y,
    input  logic [20:0] v_z,
    output logic        op_issue,
    output logic [20:0] op_a,
    output logic [20:0] op_b,
    output logic [20:0] op_c,
    output logic [20:0] op_d,
    input  logic [20:0] res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] n_x,
    output logic [20:0] n_y,
    output logic [20:0] n_z
);

    typedef enum logic [2:0] {IDLE, ISS_X, ISS_Y, ISS_Z, WAIT, HOLD} state_t;

    localparam logic [1:0] ID_X = 2'd0;
    localparam logic [1:0] ID_Y = 2'd1;
    localparam logic [1:0] ID_Z = 2'd2;

    state_t      state;
    state_t      state_next;

    logic [20:0] ux_q, uy_q, uz_q, vx_q, vy_q, vz_q;

    logic [LAT-1:0] tag_vld;
    logic [1:0]     tag_id [LAT];
    logic [1:0]     issue_id;
    logic           exit_vld;
    logic [1:0]     exit_id;
    logic [20:0]    res_cap;

    // Flips only the sign bit so the datapath's add becomes a subtract.
    function automatic logic [20:0] negate(input logic [20:0] f);
        return {~f[20], f[19:0]};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign exit_vld  = tag_vld[LAT-1];
    assign exit_id   = tag_id[LAT-1];

`ifdef CROSS_SEQ_ZERO_FLUSH_EN
    localparam int FRAC_W = 13;
    localparam int EXP_W  = 7;
    assign res_cap = (res[FRAC_W +: EXP_W] == '0) ? '0 : res;
`else
    assign res_cap = res;
`endif

    // Next-state and datapath operand selection. Operands are only driven in
    // the three issue states; everywhere else the bus is held at zero.
    always_comb begin
        state_next = state;
        op_issue   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_c       = '0;
        op_d       = '0;
        issue_id   = ID_X;
        case (state)
            IDLE: begin
                if (in_valid) state_next = ISS_X;
            end
            ISS_X: begin
                op_issue   = 1'b1;
                op_a       = uy_q;
                op_b       = vz_q;
                op_c       = negate(uz_q);
                op_d       = vy_q;
                issue_id   = ID_X;
                state_next = ISS_Y;
            end
            ISS_Y: begin
                op_issue   = 1'b1;
                op_a       = uz_q;
                op_b       = vx_q;
                op_c       = negate(ux_q);
                op_d       = vz_q;
                issue_id   = ID_Y;
                state_next = ISS_Z;
            end
            ISS_Z: begin
                op_issue   = 1'b1;
                op_a       = ux_q;
                op_b       = vy_q;
                op_c       = negate(uy_q);
                op_d       = vx_q;
                issue_id   = ID_Z;
                state_next = WAIT;
            end
            WAIT: begin
                // The Z job is issued last, so its return completes the vector.
                if (exit_vld && (exit_id == ID_Z)) state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and operand latch. Operands are captured only on the
    // accept handshake so they stay stable for all three issue cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ux_q  <= '0;
            uy_q  <= '0;
            uz_q  <= '0;
            vx_q  <= '0;
            vy_q  <= '0;
            vz_q  <= '0;
        end else begin
            state <= state_next;
            if (in_valid && in_ready) begin
                ux_q <= u_x;
                uy_q <= u_y;
                uz_q <= u_z;
                vx_q <= v_x;
                vy_q <= v_y;
                vz_q <= v_z;
            end
        end
    end

    // Tag pipeline mirrors the datapath latency: a tag leaves the last stage
    // exactly when its result appears on res. Clearing it on reset is what
    // drops any results still in flight in the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int i = 0; i < LAT; i++) tag_id[i] <= ID_X;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
            tag_vld[0] <= op_issue;
            tag_id[0]  <= issue_id;
        end
    end

    // Result capture, steered by the exiting tag; res is ignored otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_x <= '0;
            n_y <= '0;
            n_z <= '0;
        end else if (exit_vld) begin
            case (exit_id)
                ID_X:    n_x <= res_cap;
                ID_Y:    n_y <= res_cap;
                ID_Z:    n_z <= res_cap;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cross_product_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cross_product_sequencer
//
// Drives cross_product_sequencer with a behavioural FP21 multiply-add
// datapath (LAT cycles deep). Expected cross products are computed directly
// from u and v, pushed to a scoreboard at accept time, and popped when the
// DUT presents a result.
// ---------------------------------------------------------------------------
module tb_cross_product_sequencer;

    localparam int LAT = 4;

    typedef struct packed {
        logic [20:0] x;
        logic [20:0] y;
        logic [20:0] z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [20:0] u_x = '0, u_y = '0, u_z = '0;
    logic [20:0] v_x = '0, v_y = '0, v_z = '0;
    logic        op_issue;
    logic [20:0] op_a, op_b, op_c, op_d;
    logic [20:0] res;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [20:0] n_x, n_y, n_z;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb[$];

    logic [20:0] pipe [LAT];
    int          iss_cnt = 0;
    bit          inject_x = 1'b0;

    cross_product_sequencer #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .u_x(u_x), .u_y(u_y), .u_z(u_z),
        .v_x(v_x), .v_y(v_y), .v_z(v_z),
        .op_issue(op_issue),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .res(res),
        .out_valid(out_valid), .out_ready(out_ready),
        .n_x(n_x), .n_y(n_y), .n_z(n_z)
    );

    // Free-running clock and cycle counter used for latency measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FP21 to real; zero-exponent words are treated as zero.
    function automatic real fp2r(input logic [20:0] f);
        real r;
        int  e;
        if (f[19:13] == 7'd0) return 0.0;
        r = 1.0 + real'(f[12:0]) / 8192.0;
        e = int'(f[19:13]) - 63;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[20] ? -r : r;
    endfunction

    // Real to FP21 (bias 63), round to nearest; exact for the small values used.
    function automatic logic [20:0] r2fp(input real r);
        real  a;
        int   e;
        int   m;
        logic s;
        if (r == 0.0) return '0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 63;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = int'((a - 1.0) * 8192.0);
        return {s, 7'(e), 13'(m)};
    endfunction

    function automatic vec_t mk(input real x, input real y, input real z);
        vec_t r;
        r.x = r2fp(x);
        r.y = r2fp(y);
        r.z = r2fp(z);
        return r;
    endfunction

    // Reference cross product straight from the textbook formula.
    function automatic vec_t cross_ref(input vec_t u, input vec_t v);
        vec_t r;
        r.x = r2fp(fp2r(u.y) * fp2r(v.z) - fp2r(u.z) * fp2r(v.y));
        r.y = r2fp(fp2r(u.z) * fp2r(v.x) - fp2r(u.x) * fp2r(v.z));
        r.z = r2fp(fp2r(u.x) * fp2r(v.y) - fp2r(u.y) * fp2r(v.x));
        return r;
    endfunction

    // Behavioural datapath: (a*b)+(c*d) delayed LAT clocks. Idle slots carry a
    // junk word so stray captures show up. inject_x forces a denormal onto
    // every X job.
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        if (rst) iss_cnt <= 0;
        else if (op_issue) iss_cnt <= iss_cnt + 1;
        if (op_issue) begin
            if (inject_x && (iss_cnt % 3 == 0)) pipe[0] <= 21'h000001;
            else pipe[0] <= r2fp(fp2r(op_a) * fp2r(op_b) + fp2r(op_c) * fp2r(op_d));
        end else begin
            pipe[0] <= 21'h1ABCD;
        end
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign res = pipe[LAT-1];

    // Presents u, v starting at the current negedge and holds in_valid until
    // the DUT is ready; acc is the cycle count just before the accept edge.
    task automatic offer(input vec_t u, input vec_t v, output int acc, output bit ok);
        u_x = u.x; u_y = u.y; u_z = u.z;
        v_x = v.x; v_y = v.y; v_z = v.z;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Advances negedge by negedge until out_valid is seen, bounded.
    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        n_cmp++;
        if ({out_valid, op_issue} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL reset_flags: got out_valid=%b op_issue=%b, expected 0 0", out_valid, op_issue);
        end
        n_cmp++;
        if ({op_a, op_b, op_c, op_d} !== 84'd0) begin
            n_bad++; $display("[TB] FAIL reset_ops: got %h %h %h %h, expected zeros", op_a, op_b, op_c, op_d);
        end
        n_cmp++;
        if ({n_x, n_y, n_z} !== 63'd0) begin
            n_bad++; $display("[TB] FAIL reset_n: got %h %h %h, expected zeros", n_x, n_y, n_z);
        end
    endtask

    task automatic test_unit_vectors;
        vec_t u, v, e;
        int   acc;
        bit   ok;
        u = mk(1.0, 0.0, 0.0);
        v = mk(0.0, 1.0, 0.0);
        out_ready = 1'b1;
        offer(u, v, acc, ok);
        sb.push_back({21'h000000, 21'h000000, 21'h07E000});
        wait_out_valid(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++; $display("[TB] FAIL unit_timeout: got no out_valid, expected one");
        end
        n_cmp++;
        if (cyc - acc != LAT + 4) begin
            n_bad++; $display("[TB] FAIL unit_latency: got %0d, expected %0d", cyc - acc, LAT + 4);
        end
        e = sb.pop_front();
        n_cmp++;
        if ({n_x, n_y, n_z} !== {e.x, e.y, e.z}) begin
            n_bad++; $display("[TB] FAIL unit_result: got %h %h %h, expected %h %h %h", n_x, n_y, n_z, e.x, e.y, e.z);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++; $display("[TB] FAIL unit_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_general;
        vec_t u, v, e;
        int   acc;
        bit   ok;
        u = mk(1.0, 2.0, 3.0);
        v = mk(4.0, 5.0, 6.0);
        offer(u, v, acc, ok);
        sb.push_back(cross_ref(u, v));
        n_cmp++;
        if ({op_issue, op_a, op_c} !== {1'b1, r2fp(2.0), r2fp(-3.0)}) begin
            n_bad++; $display("[TB] FAIL iss_x_ops: got %b %h %h, expected 1 %h %h", op_issue, op_a, op_c, r2fp(2.0), r2fp(-3.0));
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({op_issue, op_a, op_b, op_c, op_d} !== {1'b1, r2fp(1.0), r2fp(5.0), r2fp(-2.0), r2fp(4.0)}) begin
            n_bad++; $display("[TB] FAIL iss_z_ops: got %b %h %h %h %h, expected 1 %h %h %h %h", op_issue, op_a, op_b, op_c, op_d,
                              r2fp(1.0), r2fp(5.0), r2fp(-2.0), r2fp(4.0));
        end
        @(negedge clk);
        n_cmp++;
        if ({op_issue, op_a, op_b, op_c, op_d} !== 85'd0) begin
            n_bad++; $display("[TB] FAIL wait_ops: got %b %h %h %h %h, expected zeros", op_issue, op_a, op_b, op_c, op_d);
        end
        wait_out_valid(ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || {n_x, n_y, n_z} !== {e.x, e.y, e.z} || e !== mk(-3.0, 6.0, -3.0)) begin
            n_bad++; $display("[TB] FAIL general_result: got %h %h %h, expected %h %h %h", n_x, n_y, n_z, e.x, e.y, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        vec_t u, v, e, snap;
        int   acc;
        bit   ok;
        u = mk(2.0, 0.0, 1.0);
        v = mk(1.0, 3.0, 0.0);
        out_ready = 1'b0;
        offer(u, v, acc, ok);
        sb.push_back(cross_ref(u, v));
        wait_out_valid(ok);
        snap = {n_x, n_y, n_z};
        u_x = r2fp(7.0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, n_x, n_y, n_z} !== {2'b10, snap}) begin
                n_bad++; $display("[TB] FAIL hold_stable: got ov=%b ir=%b %h %h %h, expected 1 0 %h %h %h",
                                  out_valid, in_ready, n_x, n_y, n_z, snap.x, snap.y, snap.z);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        n_cmp++;
        if (!ok || {n_x, n_y, n_z} !== {e.x, e.y, e.z}) begin
            n_bad++; $display("[TB] FAIL hold_result: got %h %h %h, expected %h %h %h", n_x, n_y, n_z, e.x, e.y, e.z);
        end
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, op_issue} !== 2'b00) begin
                n_bad++; $display("[TB] FAIL hold_no_accept: got ov=%b issue=%b, expected 0 0", out_valid, op_issue);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        bit ok;
        offer(mk(1.0, 2.0, 3.0), mk(4.0, 5.0, 6.0), acc, ok);
        // Now in ISS_X; four more negedges lands in the second WAIT cycle.
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("[TB] FAIL rstmid_in_ready: got %b, expected 1", in_ready);
        end
        for (int i = 0; i < LAT + 6; i++) begin
            n_cmp++;
            if ({out_valid, n_x, n_y, n_z} !== 64'd0) begin
                n_bad++; $display("[TB] FAIL rstmid_quiet: got ov=%b %h %h %h, expected 0 zeros", out_valid, n_x, n_y, n_z);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush;
        vec_t u, v, e;
        int   acc;
        bit   ok;
        u = mk(1.0, 2.0, 3.0);
        v = mk(4.0, 5.0, 6.0);
        inject_x = 1'b1;
        offer(u, v, acc, ok);
        e = cross_ref(u, v);
`ifdef CROSS_SEQ_ZERO_FLUSH_EN
        e.x = 21'h000000;
`else
        e.x = 21'h000001;
`endif
        sb.push_back(e);
        wait_out_valid(ok);
        inject_x = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (!ok || {n_x, n_y, n_z} !== {e.x, e.y, e.z}) begin
            n_bad++; $display("[TB] FAIL flush_result: got %h %h %h, expected %h %h %h", n_x, n_y, n_z, e.x, e.y, e.z);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        vec_t u, v, e;
        int   accs[4];
        int   k = 0;
        bit   pending = 1'b0;
        out_ready = 1'b1;
        u = mk(1.0, 2.0, -1.0);
        v = mk(3.0, 0.0, 1.0);
        {u_x, u_y, u_z} = u;
        {v_x, v_y, v_z} = v;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && (k < 4 || sb.size() > 0); c++) begin
            if (pending) begin
                pending = 1'b0;
                if (k < 4) begin
                    u = mk(real'(k + 1), 2.0, -1.0);
                    v = mk(3.0, real'(k), 1.0);
                    {u_x, u_y, u_z} = u;
                    {v_x, v_y, v_z} = v;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({n_x, n_y, n_z} !== {e.x, e.y, e.z}) begin
                    n_bad++; $display("[TB] FAIL b2b_result: got %h %h %h, expected %h %h %h", n_x, n_y, n_z, e.x, e.y, e.z);
                end
            end
            if (in_valid && in_ready && k < 4) begin
                sb.push_back(cross_ref(u, v));
                accs[k] = cyc;
                k++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (k != 4 || sb.size() != 0) begin
            n_bad++; $display("[TB] FAIL b2b_timeout: got %0d accepts %0d pending, expected 4 0", k, sb.size());
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (accs[i] - accs[i-1] != LAT + 5) begin
                n_bad++; $display("[TB] FAIL b2b_spacing: got %0d, expected %0d", accs[i] - accs[i-1], LAT + 5);
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_unit_vectors();
        test_general();
        test_hold();
        test_reset_mid();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cross_product_sequencer.md
CROSS_PRODUCT_SEQUENCER -- requirements
Module: cross_product_sequencer

Interface
REQ-001 Parameter: LAT, default 4, total latency of the external multiply-add datapath in clocks; legal range 1..16.
REQ-002 FP21 word (21 bits) SHALL be packed {sign, exp[`exp:0], frac[`frac:0]} per the FP21 definitions header.
REQ-003 clk  input  1  rising-edge clock; reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  source offers vector pair u, v.
REQ-006 in_ready  output  1  block accepts u, v this cycle.
REQ-007 u_x, u_y, u_z, v_x, v_y, v_z  input  21 each  operand vectors.
REQ-008 op_issue  output  1  operands on op_a..op_d are valid this cycle.
REQ-009 op_a, op_b, op_c, op_d  output  21 each  datapath operands; the datapath computes (a*b)+(c*d).
REQ-010 res  input  21  datapath result, valid LAT cycles after the matching op_issue.
REQ-011 out_valid  output  1  n_x, n_y, n_z hold u x v.
REQ-012 out_ready  input  1  sink consumes the result.
REQ-013 n_x, n_y, n_z  output  21 each  cross-product result.

Function
REQ-014 FSM states SHALL be IDLE, ISS_X, ISS_Y, ISS_Z, WAIT, HOLD; in_ready SHALL equal (state==IDLE).
REQ-015 On in_valid & in_ready, u and v SHALL be latched; state IDLE->ISS_X; in_valid outside IDLE SHALL be ignored.
REQ-016 ISS_X, ISS_Y, ISS_Z SHALL each last one cycle with op_issue=1, then ISS_Y, ISS_Z, WAIT respectively.
REQ-017 ISS_X: a=u_y, b=v_z, c=u_z with sign inverted, d=v_y.
REQ-018 ISS_Y: a=u_z, b=v_x, c=u_x with sign inverted, d=v_z.
REQ-019 ISS_Z: a=u_x, b=v_y, c=u_y with sign inverted, d=v_x.
REQ-020 Outside issue states, op_issue=0 and op_a..op_d SHALL be zero.
REQ-021 A LAT-deep tag shift register SHALL carry {valid, component id} per issue; when the tag exits, res SHALL be captured into n_x/n_y/n_z per id.
REQ-022 When the Z tag exits, state WAIT->HOLD and out_valid SHALL rise the next cycle, i.e. LAT+4 cycles after the accept edge.
REQ-023 HOLD: n_* and out_valid SHALL stay stable until out_ready=1; then state->IDLE and out_valid falls the next cycle.
REQ-024 out_ready while out_valid=0 SHALL have no effect; n_* SHALL keep their last value until overwritten.
REQ-025 Throughput SHALL be one vector per LAT+5 cycles when out_ready is held high.
REQ-026 res SHALL be ignored on cycles with no valid tag exiting.

Reset
REQ-027 rst SHALL force state=IDLE, clear all tags, and zero out_valid, op_issue, op_a..op_d, n_x, n_y, n_z, and the latched operands.
REQ-028 rst mid-operation SHALL discard in-flight datapath results; no capture SHALL occur from issues made before reset.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 With CROSS_SEQ_ZERO_FLUSH_EN defined, a captured res with exp==0 SHALL be stored as +0 (all 21 bits zero).
REQ-031 Without CROSS_SEQ_ZERO_FLUSH_EN, res SHALL be stored bit-exact.

Verification
REQ-032 LAT=4, behavioural datapath; u=(1.0,0,0), v=(0,1.0,0) -> n=(+0,+0,1.0); out_valid 8 cycles after accept.
REQ-033 u=(1.0,2.0,3.0), v=(4.0,5.0,6.0) -> n=(-3.0,6.0,-3.0); ISS_Z cycle shows a=1.0, b=5.0, c=-2.0, d=4.0.
REQ-034 out_ready held low 10 cycles after out_valid -> n_* stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-035 rst asserted in cycle 2 of WAIT -> out_valid stays 0, no n_* change, in_ready=1 one cycle after rst falls.
REQ-036 Datapath returns a denormal (exp=0, frac=1) for X -> n_x=0 with CROSS_SEQ_ZERO_FLUSH_EN, n_x raw without it.
REQ-037 Back-to-back vectors with out_ready=1 and in_valid=1 -> accepts spaced exactly LAT+5 cycles.
